// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- fetch program-counter unit.
//
// Holds the fetch PC and steps it sequentially by INC. It also handles stall,
// branch redirect, trap vectoring, misaligned branch-target detection and a
// small circular return-address stack (RAS).
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_i            asynchronous active-low reset
//   stall_i          hold PC (lowest-priority control)
//   branch_i         redirect to branch_target_i
//   branch_target_i  redirect address
//   call_i           qualifies branch_i as a call (pushes return address)
//   ret_i            predicted return (pops RAS when non-empty)
//   trap_i           vector to TRAP_VECTOR and flush the RAS
//   pc_o             current fetch PC (registered)
//   pc_next_o        pc_o + INC, modulo 2^XLEN (combinational)
//   pc_valid_o       pc_o is a valid fetch address
//   misaligned_o     one-cycle flag after a misaligned branch target
//   ras_empty_o      RAS count == 0
//   ras_full_o       RAS count == RAS_DEPTH
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              INC          = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            call_i,
  input  logic            ret_i,
  input  logic            trap_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            pc_valid_o,
  output logic            misaligned_o,
  output logic            ras_empty_o,
  output logic            ras_full_o
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [XLEN-1:0]  INC_V    = XLEN'(INC);

  logic [XLEN-1:0]  r_pc;
  logic             r_valid;
  logic             r_mis;
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_ras [RAS_DEPTH];

  logic [XLEN-1:0]  w_pc_next;
  logic [XLEN-1:0]  w_pc_d;
  logic             w_mis_d;
  logic [PTR_W-1:0] w_top_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_push;
  logic [PTR_W-1:0] w_top_inc;
  logic [PTR_W-1:0] w_top_dec;

  // Sequential successor; the adder simply drops the carry so it wraps.
  assign w_pc_next = r_pc + INC_V;

  // Circular top-pointer neighbours; explicit wrap keeps non-power-of-two depths correct.
  always_comb begin
    w_top_inc = r_top + 1'b1;
    w_top_dec = r_top - 1'b1;
    if (r_top == PTR_LAST) begin
      w_top_inc = '0;
    end else begin
      w_top_inc = r_top + 1'b1;
    end
    if (r_top == '0) begin
      w_top_dec = PTR_LAST;
    end else begin
      w_top_dec = r_top - 1'b1;
    end
  end

  // Prioritised next-PC and RAS control selection.
  always_comb begin
    w_pc_d  = r_pc;
    w_mis_d = 1'b0;
    w_top_d = r_top;
    w_cnt_d = r_cnt;
    w_push  = 1'b0;
    if (!r_valid) begin
      // First edge after reset only raises valid; controls are ignored.
      w_pc_d = r_pc;
    end else if (trap_i) begin
      w_pc_d  = TRAP_VECTOR;
      w_cnt_d = '0;
    end else if (branch_i && (branch_target_i[1:0] != 2'b00)) begin
      w_pc_d  = TRAP_VECTOR;
      w_mis_d = 1'b1;
    end else if (branch_i) begin
      w_pc_d = branch_target_i;
      if (call_i) begin
        // Push when full overwrites the oldest slot; count saturates.
        w_push  = 1'b1;
        w_top_d = w_top_inc;
        if (r_cnt != CNT_FULL) begin
          w_cnt_d = r_cnt + 1'b1;
        end else begin
          w_cnt_d = r_cnt;
        end
      end else begin
        w_push = 1'b0;
      end
    end else if (ret_i && (r_cnt != '0)) begin
      w_pc_d  = r_ras[r_top];
      w_top_d = w_top_dec;
      w_cnt_d = r_cnt - 1'b1;
    end else if (stall_i) begin
      w_pc_d = r_pc;
    end else begin
      // Also covers ret_i with an empty RAS.
      w_pc_d = w_pc_next;
    end
  end

  // PC, valid, misaligned flag and RAS bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc    <= RESET_VECTOR;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
      r_top   <= '0;
      r_cnt   <= '0;
    end else begin
      r_pc    <= w_pc_d;
      r_valid <= 1'b1;
      r_mis   <= w_mis_d;
      r_top   <= w_top_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Return-address storage; the return address is the pre-update pc_o + INC.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= '0;
      end
    end else if (w_push) begin
      r_ras[w_top_d] <= w_pc_next;
    end else begin
      r_ras[r_top] <= r_ras[r_top];
    end
  end

  assign pc_o         = r_pc;
  assign pc_next_o    = w_pc_next;
  assign pc_valid_o   = r_valid;
  assign misaligned_o = r_mis;
  assign ras_empty_o  = (r_cnt == '0);
  assign ras_full_o   = (r_cnt == CNT_FULL);

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit -- directed, table-driven bench for pc_unit (default parameters).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_pc_unit;

  logic        clk_i;
  logic        rst_i;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        call_i;
  logic        ret_i;
  logic        trap_i;
  logic [31:0] pc_o;
  logic [31:0] pc_next_o;
  logic        pc_valid_o;
  logic        misaligned_o;
  logic        ras_empty_o;
  logic        ras_full_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        stall;
    logic        branch;
    logic        call;
    logic        ret;
    logic        trap;
    logic [31:0] target;
    logic [31:0] pc;
    logic        mis;
    logic        empty;
    logic        full;
  } vec_t;

  vec_t tv[$];

  pc_unit dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .call_i          (call_i),
    .ret_i           (ret_i),
    .trap_i          (trap_i),
    .pc_o            (pc_o),
    .pc_next_o       (pc_next_o),
    .pc_valid_o      (pc_valid_o),
    .misaligned_o    (misaligned_o),
    .ras_empty_o     (ras_empty_o),
    .ras_full_o      (ras_full_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // stall, branch, call, ret, trap, target, expected pc, mis, empty, full
  task automatic add(input logic s, input logic b, input logic c, input logic r,
                     input logic t, input logic [31:0] tgt, input logic [31:0] epc,
                     input logic m, input logic e, input logic f);
    vec_t v;
    v.stall = s; v.branch = b; v.call = c; v.ret = r; v.trap = t;
    v.target = tgt; v.pc = epc; v.mis = m; v.empty = e; v.full = f;
    tv.push_back(v);
  endtask

  task automatic idle_inputs();
    stall_i = 1'b0; branch_i = 1'b0; call_i = 1'b0; ret_i = 1'b0; trap_i = 1'b0;
    branch_target_i = 32'h0000_0000;
  endtask

  initial begin
    // sequential run after reset
    add(0,0,0,0,0, 32'h0,        32'h0000_0004, 0,1,0);
    add(0,0,0,0,0, 32'h0,        32'h0000_0008, 0,1,0);
    add(0,0,0,0,0, 32'h0,        32'h0000_000C, 0,1,0);
    add(0,0,0,0,0, 32'h0,        32'h0000_0010, 0,1,0);
    // stall vs redirect
    add(1,0,0,0,0, 32'h0,        32'h0000_0010, 0,1,0);
    add(1,0,0,0,0, 32'h0,        32'h0000_0010, 0,1,0);
    add(1,1,0,0,0, 32'h40,       32'h0000_0040, 0,1,0);
    // call / return
    add(0,1,0,0,0, 32'h20,       32'h0000_0020, 0,1,0);
    add(0,1,1,0,0, 32'h80,       32'h0000_0080, 0,0,0);
    add(0,0,0,0,0, 32'h0,        32'h0000_0084, 0,0,0);
    add(0,0,0,0,0, 32'h0,        32'h0000_0088, 0,0,0);
    add(0,0,0,1,0, 32'h0,        32'h0000_0024, 0,1,0);
    // RAS overflow: pushes 28, 204, 304, 404, 504 (504 overwrites 28)
    add(0,1,1,0,0, 32'h200,      32'h0000_0200, 0,0,0);
    add(0,1,1,0,0, 32'h300,      32'h0000_0300, 0,0,0);
    add(0,1,1,0,0, 32'h400,      32'h0000_0400, 0,0,0);
    add(0,1,1,0,0, 32'h500,      32'h0000_0500, 0,0,1);
    add(0,1,1,0,0, 32'h600,      32'h0000_0600, 0,0,1);
    add(0,0,0,1,0, 32'h0,        32'h0000_0504, 0,0,0);
    add(0,0,0,1,0, 32'h0,        32'h0000_0404, 0,0,0);
    add(0,0,0,1,0, 32'h0,        32'h0000_0304, 0,0,0);
    add(0,0,0,1,0, 32'h0,        32'h0000_0204, 0,1,0);
    add(0,0,0,1,0, 32'h0,        32'h0000_0208, 0,1,0);
    // call without branch is ignored; ret overrides stall
    add(0,0,1,0,0, 32'h0,        32'h0000_020C, 0,1,0);
    add(0,1,1,0,0, 32'h700,      32'h0000_0700, 0,0,0);
    add(1,0,0,1,0, 32'h0,        32'h0000_0210, 0,1,0);
    // misaligned branch
    add(0,1,0,0,0, 32'h42,       32'h0000_0100, 1,1,0);
    add(0,0,0,0,0, 32'h0,        32'h0000_0104, 0,1,0);
    add(0,1,1,0,0, 32'h800,      32'h0000_0800, 0,0,0);
    add(0,1,1,0,0, 32'h802,      32'h0000_0100, 1,0,0);
    // trap with ret flushes RAS; following ret is sequential
    add(0,0,0,1,1, 32'h0,        32'h0000_0100, 0,1,0);
    add(0,0,0,1,0, 32'h0,        32'h0000_0104, 0,1,0);
    add(0,1,1,0,0, 32'hC00,      32'h0000_0C00, 0,0,0);
    add(0,1,1,0,1, 32'h40,       32'h0000_0100, 0,1,0);
    // wrap
    add(0,1,0,0,0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0,1,0);
    add(0,0,0,0,0, 32'h0,        32'h0000_0000, 0,1,0);
    // branch+call with ret: ret ignored, push happens
    add(0,1,1,1,0, 32'h900,      32'h0000_0900, 0,0,0);

    // reset phase
    idle_inputs();
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset pc",       pc_o,                32'h0000_0000);
    chk("reset valid",    {31'd0, pc_valid_o}, 32'd0);
    chk("reset mis",      {31'd0, misaligned_o}, 32'd0);
    chk("reset empty",    {31'd0, ras_empty_o}, 32'd1);
    chk("reset full",     {31'd0, ras_full_o},  32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("first edge valid", {31'd0, pc_valid_o}, 32'd1);
    chk("first edge pc",    pc_o,                32'h0000_0000);

    // table
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk_i);
      stall_i = tv[i].stall; branch_i = tv[i].branch; call_i = tv[i].call;
      ret_i = tv[i].ret; trap_i = tv[i].trap; branch_target_i = tv[i].target;
      @(posedge clk_i); #1;
      chk($sformatf("vec%0d pc", i),      pc_o,                    tv[i].pc);
      chk($sformatf("vec%0d pc_next", i), pc_next_o,               tv[i].pc + 32'd4);
      chk($sformatf("vec%0d valid", i),   {31'd0, pc_valid_o},     32'd1);
      chk($sformatf("vec%0d mis", i),     {31'd0, misaligned_o},   {31'd0, tv[i].mis});
      chk($sformatf("vec%0d empty", i),   {31'd0, ras_empty_o},    {31'd0, tv[i].empty});
      chk($sformatf("vec%0d full", i),    {31'd0, ras_full_o},     {31'd0, tv[i].full});
    end

    // asynchronous reset mid-cycle with stall pending
    @(negedge clk_i);
    idle_inputs();
    stall_i = 1'b1;
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("midrst pc",    pc_o,                 32'h0000_0000);
    chk("midrst valid", {31'd0, pc_valid_o},  32'd0);
    chk("midrst empty", {31'd0, ras_empty_o}, 32'd1);
    // controls ignored on the first edge after reset release
    @(negedge clk_i);
    stall_i = 1'b0; branch_i = 1'b1; branch_target_i = 32'h0000_0040;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("ignore ctl pc",    pc_o,                32'h0000_0000);
    chk("ignore ctl valid", {31'd0, pc_valid_o}, 32'd1);
    @(negedge clk_i);
    idle_inputs();
    @(posedge clk_i); #1;
    chk("post rst step pc",    pc_o,                 32'h0000_0004);
    chk("post rst step empty", {31'd0, ras_empty_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
